// File: rtl/alarm_time_setter.sv
// Alarm time setter: two raw keys drive a BCD HH:MM edit FSM.
// Ports: CLK, RST (async, active-high), key_mode, key_inc (raw buttons);
//   hour_t, hour_o, min_t, min_o (BCD digits), blink_en (per-digit blink
//   enable [3]=hour_t..[0]=min_o), setting (not IDLE), done (commit pulse).
// Optional macro DEBOUNCE_EN adds a DEB_CYCLES stable-level debouncer.
module alarm_time_setter #(
    parameter int DEB_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [3:0] hour_t,
    output logic [3:0] hour_o,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] blink_en,
    output logic       setting,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    // Bit 0 = mode key, bit 1 = inc key.
    logic [1:0] raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] lvl;
    logic [1:0] prev_q;
    logic [1:0] armed_q;
    logic [1:0] warm_q;
    logic [1:0] press;

    assign raw = {key_inc, key_mode};

    // warm_q[1] rises once the synchronizers hold post-reset samples, so a
    // key held across reset release is seen as held, never as a new press.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            prev_q  <= 2'b00;
            armed_q <= 2'b00;
            warm_q  <= 2'b00;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            prev_q  <= lvl;
            warm_q  <= {warm_q[0], 1'b1};
            armed_q <= armed_q | ({2{warm_q[1]}} & ~sync2_q & ~lvl);
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]    lvl_q;
    logic [CW-1:0] cnt_q [2];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lvl_q    <= 2'b00;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == lvl_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    lvl_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = sync2_q;
`endif

    assign press = lvl & ~prev_q & armed_q;

    // Next BCD values for one increment step.
    logic [3:0] hour_t_d, hour_o_d, min_t_d, min_o_d;
    logic [3:0] hour_t_q, hour_o_q, min_t_q, min_o_q;

    always_comb begin
        hour_t_d = hour_t_q;
        hour_o_d = hour_o_q;
        if (hour_t_q == 4'd2 && hour_o_q == 4'd3) begin
            hour_t_d = 4'd0;
            hour_o_d = 4'd0;
        end else if (hour_o_q == 4'd9) begin
            hour_t_d = hour_t_q + 4'd1;
            hour_o_d = 4'd0;
        end else begin
            hour_o_d = hour_o_q + 4'd1;
        end
    end

    always_comb begin
        min_t_d = min_t_q;
        min_o_d = min_o_q;
        if (min_o_q == 4'd9) begin
            min_o_d = 4'd0;
            min_t_d = (min_t_q == 4'd5) ? 4'd0 : min_t_q + 4'd1;
        end else begin
            min_o_d = min_o_q + 4'd1;
        end
    end

    state_t     state_q;
    logic [3:0] blink_q;
    logic       setting_q;
    logic       done_q;

    // Mode takes priority: an inc press on the same cycle is dropped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            hour_t_q  <= 4'd0;
            hour_o_q  <= 4'd0;
            min_t_q   <= 4'd0;
            min_o_q   <= 4'd0;
            blink_q   <= 4'b0000;
            setting_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (press[0]) begin
                unique case (state_q)
                    IDLE: begin
                        state_q   <= SET_HOUR;
                        blink_q   <= 4'b1100;
                        setting_q <= 1'b1;
                    end
                    SET_HOUR: begin
                        state_q   <= SET_MIN;
                        blink_q   <= 4'b0011;
                        setting_q <= 1'b1;
                    end
                    SET_MIN: begin
                        state_q   <= IDLE;
                        blink_q   <= 4'b0000;
                        setting_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                    default: begin
                        state_q   <= IDLE;
                        blink_q   <= 4'b0000;
                        setting_q <= 1'b0;
                    end
                endcase
            end else if (press[1]) begin
                if (state_q == SET_HOUR) begin
                    hour_t_q <= hour_t_d;
                    hour_o_q <= hour_o_d;
                end else if (state_q == SET_MIN) begin
                    min_t_q <= min_t_d;
                    min_o_q <= min_o_d;
                end
            end
        end
    end

    assign hour_t   = hour_t_q;
    assign hour_o   = hour_o_q;
    assign min_t    = min_t_q;
    assign min_o    = min_o_q;
    assign blink_en = blink_q;
    assign setting  = setting_q;
    assign done     = done_q;

endmodule

// File: tb/tb_alarm_time_setter.sv
// Directed bench for alarm_time_setter: vector table of key presses with
// expected HH:MM, blink/setting and done counts, plus corner sequences.
module tb_alarm_time_setter;

    localparam int DEB = 16;
`ifdef DEBOUNCE_EN
    localparam int D = DEB;
`else
    localparam int D = 0;
`endif
    localparam int HOLD   = D + 4;
    localparam int SETTLE = D + 6;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic [3:0] hour_t, hour_o, min_t, min_o, blink_en;
    logic       setting, done;

    alarm_time_setter #(.DEB_CYCLES(DEB)) dut (
        .CLK(CLK), .RST(RST),
        .key_mode(key_mode), .key_inc(key_inc),
        .hour_t(hour_t), .hour_o(hour_o),
        .min_t(min_t), .min_o(min_o),
        .blink_en(blink_en), .setting(setting), .done(done)
    );

    always #5 CLK = ~CLK;

    int ncmp = 0;
    int nfail = 0;
    int done_cnt = 0;

    always @(negedge CLK) if (done === 1'b1) done_cnt++;

    typedef struct {
        bit         m;
        bit         i;
        logic [15:0] tm;
        logic [3:0] bl;
        logic       st;
        int         dd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit m, bit i, int hh, int mm,
                                logic [3:0] bl, logic st, int dd);
        vec_t v;
        v.m  = m;
        v.i  = i;
        v.tm = {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
        v.bl = bl;
        v.st = st;
        v.dd = dd;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse(bit m, bit i);
        key_mode = m;
        key_inc  = i;
        tick(HOLD);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        tick(SETTLE);
    endtask

    function automatic logic [15:0] tnow();
        return {hour_t, hour_o, min_t, min_o};
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(4);
    endtask

    initial begin
        int d0;
        for (int h = 1; h <= 29; h++)
            tbl.push_back(mk(0, 1, h % 24, 0, 4'b1100, 1, 0));
        tbl.push_back(mk(1, 0, 5, 0, 4'b0011, 1, 0));
        for (int m = 1; m <= 59; m++)
            tbl.push_back(mk(0, 1, 5, m, 4'b0011, 1, 0));
        tbl.push_back(mk(0, 1, 5, 0, 4'b0011, 1, 0));
        tbl.push_back(mk(1, 0, 5, 0, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 1, 5, 0, 4'b0000, 0, 0));

        // Reset state while RST held.
        tick(3);
        chk("rst_time", 32'(tnow()), 32'h0000);
        chk("rst_blink", 32'(blink_en), 32'h0);
        chk("rst_setting", 32'(setting), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        RST = 1'b0;
        tick(4);

        // Exact latency of the first mode press.
        key_mode = 1'b1;
        tick(2 + D);
        chk("lat_before", 32'(setting), 32'h0);
        tick(1);
        chk("lat_setting", 32'(setting), 32'h1);
        chk("lat_blink", 32'(blink_en), 32'hC);
        key_mode = 1'b0;
        tick(SETTLE);

        foreach (tbl[n]) begin
            d0 = done_cnt;
            pulse(tbl[n].m, tbl[n].i);
            chk($sformatf("v%0d_time", n), 32'(tnow()), 32'(tbl[n].tm));
            chk($sformatf("v%0d_blink", n), 32'(blink_en), 32'(tbl[n].bl));
            chk($sformatf("v%0d_set", n), 32'(setting), 32'(tbl[n].st));
            chk($sformatf("v%0d_done", n), done_cnt - d0, tbl[n].dd);
        end

        // Mode and inc on the same cycle: mode wins, hour stays.
        pulse(1, 0);
        chk("sim_pre_blink", 32'(blink_en), 32'hC);
        d0 = done_cnt;
        pulse(1, 1);
        chk("sim_blink", 32'(blink_en), 32'h3);
        chk("sim_time", 32'(tnow()), 32'h0500);
        pulse(1, 0);
        chk("sim_exit_done", done_cnt - d0, 1);
        chk("sim_exit_set", 32'(setting), 32'h0);

        // Reset mid-edit at 12:34.
        do_reset();
        pulse(1, 0);
        repeat (12) pulse(0, 1);
        pulse(1, 0);
        repeat (34) pulse(0, 1);
        chk("edit_time", 32'(tnow()), 32'h1234);
        chk("edit_blink", 32'(blink_en), 32'h3);
        d0 = done_cnt;
        key_mode = 1'b1;
        tick(1);
        #2 RST = 1'b1;
        #1;
        chk("async_time", 32'(tnow()), 32'h0000);
        chk("async_set", 32'(setting), 32'h0);
        chk("async_blink", 32'(blink_en), 32'h0);
        tick(2);
        RST = 1'b0;
        tick(10 + D);
        chk("held_set", 32'(setting), 32'h0);
        key_mode = 1'b0;
        tick(SETTLE);
        chk("rel_set", 32'(setting), 32'h0);
        chk("rst_no_done", done_cnt - d0, 0);
        pulse(1, 0);
        chk("repress_set", 32'(setting), 32'h1);
        chk("repress_blink", 32'(blink_en), 32'hC);

`ifdef DEBOUNCE_EN
        do_reset();
        pulse(1, 0);
        key_inc = 1'b1;
        tick(5);
        key_inc = 1'b0;
        tick(SETTLE);
        chk("glitch_time", 32'(tnow()), 32'h0000);
        key_inc = 1'b1;
        tick(20);
        key_inc = 1'b0;
        tick(SETTLE);
        chk("deb_time", 32'(tnow()), 32'h0100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
